// File: rtl/game_pkg.sv
// Shared types and constants for the asteroid game-flow controller.
package game_pkg;

    localparam int unsigned BCD_W  = 4;
    localparam int unsigned ST_W   = 2;
    localparam int unsigned HCNT_W = 4;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; wraps at all-nines.
module bcd_counter
    import game_pkg::*;
#(
    parameter int unsigned NDIG = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  clr,
    input  logic                  inc,
    output logic [BCD_W*NDIG-1:0] q
);

    localparam int unsigned QW = BCD_W * NDIG;

    logic [QW-1:0]    q_q;
    logic [QW-1:0]    q_d;
    logic [BCD_W-1:0] digit;
    logic             carry;

    // Ripple carry from the ones digit upward; a nine with carry-in rolls to zero.
    always_comb begin
        q_d   = q_q;
        carry = inc;
        digit = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            digit = q_q[i*BCD_W +: BCD_W];
            if (carry) begin
                if (digit == BCD_W'(9)) begin
                    q_d[i*BCD_W +: BCD_W] = '0;
                end else begin
                    q_d[i*BCD_W +: BCD_W] = digit + BCD_W'(1);
                    carry                 = 1'b0;
                end
            end
        end
        if (clr) begin
            q_d = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: frame/second prescaler, input edge detect, IDLE/PLAY/OVER
// sequencing and the BCD elapsed-time and score counters.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned FRAME_HZ = 30,
    parameter int unsigned HOLD_SEC = 3
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        hit,
    input  logic        crash,
    output logic [1:0]  state,
    output logic        playing,
    output logic        hold,
    output logic        frame_tick,
    output logic [15:0] timer_bcd,
    output logic [7:0]  score_bcd
);

    localparam int unsigned DIV    = CLK_HZ / FRAME_HZ;
    localparam int unsigned PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned FCNT_W = (FRAME_HZ > 1) ? $clog2(FRAME_HZ) : 1;

    state_e              state_q, state_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic [2:0]          prev_q, prev_d;
    logic                playing_q, playing_d;
    logic                hold_q, hold_d;
    logic                frame_tick_q, frame_tick_d;

    logic rise_start, rise_hit, rise_crash;
    logic frame_hit, sec_tick, clr_pre;
    logic tmr_clr, tmr_inc, scr_clr, scr_inc;

    assign prev_d     = {start, hit, crash};
    assign rise_start = start & ~prev_q[2];
    assign rise_hit   = hit   & ~prev_q[1];
    assign rise_crash = crash & ~prev_q[0];

    assign frame_hit  = (pre_q == PRE_W'(DIV - 1));
    assign sec_tick   = frame_hit & (fcnt_q == FCNT_W'(FRAME_HZ - 1));

    // Next-state, counter controls and registered output values.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        clr_pre = 1'b0;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        scr_clr = 1'b0;
        scr_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise_start) begin
                    state_d = ST_PLAY;
                    tmr_clr = 1'b1;
                    scr_clr = 1'b1;
                    clr_pre = 1'b1;
                end
            end
            ST_PLAY: begin
                tmr_inc = sec_tick;
                if (rise_crash) begin
                    state_d = ST_OVER;
                    hcnt_d  = HCNT_W'(HOLD_SEC);
                    clr_pre = 1'b1;
                end else if (rise_hit) begin
                    scr_inc = 1'b1;
                end
            end
            ST_OVER: begin
                if (sec_tick) begin
                    hcnt_d = hcnt_q - HCNT_W'(1);
                    if (hcnt_q == HCNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Prescaler free-runs; restarts so the first second after a transition is full.
        pre_d  = frame_hit ? '0 : pre_q + PRE_W'(1);
        fcnt_d = fcnt_q;
        if (frame_hit) begin
            fcnt_d = (fcnt_q == FCNT_W'(FRAME_HZ - 1)) ? '0 : fcnt_q + FCNT_W'(1);
        end
        if (clr_pre) begin
            pre_d  = '0;
            fcnt_d = '0;
        end

        playing_d    = (state_d == ST_PLAY);
        hold_d       = (state_d == ST_OVER);
        frame_tick_d = (pre_d == PRE_W'(DIV - 1));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            pre_q        <= '0;
            fcnt_q       <= '0;
            hcnt_q       <= '0;
            prev_q       <= '0;
            playing_q    <= 1'b0;
            hold_q       <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            fcnt_q       <= fcnt_d;
            hcnt_q       <= hcnt_d;
            prev_q       <= prev_d;
            playing_q    <= playing_d;
            hold_q       <= hold_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    bcd_counter #(.NDIG(4)) timer (
        .clock  (clock),
        .resetn (resetn),
        .clr    (tmr_clr),
        .inc    (tmr_inc),
        .q      (timer_bcd)
    );

    bcd_counter #(.NDIG(2)) score (
        .clock  (clock),
        .resetn (resetn),
        .clr    (scr_clr),
        .inc    (scr_inc),
        .q      (score_bcd)
    );

    assign state      = state_q;
    assign playing    = playing_q;
    assign hold       = hold_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer plus a standalone 4-digit bcd_counter wrap check.
module tb_game_sequencer;

    localparam int unsigned CLK_HZ   = 60;
    localparam int unsigned FRAME_HZ = 30;
    localparam int unsigned HOLD_SEC = 2;
    localparam int DIV = int'(CLK_HZ / FRAME_HZ);
    localparam int SEC = DIV * int'(FRAME_HZ);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic hit   = 1'b0;
    logic crash = 1'b0;
    logic [1:0]  state;
    logic        playing, hold, frame_tick;
    logic [15:0] timer_bcd;
    logic [7:0]  score_bcd;

    logic        clr_t = 1'b0;
    logic        inc_t = 1'b0;
    logic [15:0] cnt_out;

    always #5 clk = ~clk;

    game_sequencer #(.CLK_HZ(CLK_HZ), .FRAME_HZ(FRAME_HZ), .HOLD_SEC(HOLD_SEC)) dut (
        .clock      (clk),
        .resetn     (rst_n),
        .start      (start),
        .hit        (hit),
        .crash      (crash),
        .state      (state),
        .playing    (playing),
        .hold       (hold),
        .frame_tick (frame_tick),
        .timer_bcd  (timer_bcd),
        .score_bcd  (score_bcd)
    );

    bcd_counter #(.NDIG(4)) u_cnt (
        .clock  (clk),
        .resetn (rst_n),
        .clr    (clr_t),
        .inc    (inc_t),
        .q      (cnt_out)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        ply;
        logic        hld;
        logic        ft;
        logic [15:0] tmr;
        logic [7:0]  scr;
    } snap_t;

    snap_t       exp_q[$];
    logic [15:0] cexp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state: plain integers, cycles counted since the last prescaler restart.
    int m_mode, m_phase, m_secs, m_score, c_cnt;
    bit m_ps, m_ph, m_pc;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic snap_t m_snap();
        snap_t s;
        logic [15:0] sb;
        sb    = to_bcd(m_score);
        s.st  = 2'(m_mode);
        s.ply = (m_mode == 1);
        s.hld = (m_mode == 2);
        s.ft  = ((m_phase % DIV) == DIV - 1);
        s.tmr = to_bcd(m_secs);
        s.scr = sb[7:0];
        return s;
    endfunction

    task automatic model_step();
        bit rs, rh, rc, sec_t;
        int nphase;
        rs = start && !m_ps;
        rh = hit   && !m_ph;
        rc = crash && !m_pc;
        m_ps = start; m_ph = hit; m_pc = crash;
        sec_t  = ((m_phase % SEC) == SEC - 1);
        nphase = m_phase + 1;
        case (m_mode)
            0: if (rs) begin
                m_secs = 0; m_score = 0; m_mode = 1; nphase = 0;
            end
            1: begin
                if (sec_t) m_secs = (m_secs + 1) % 10000;
                if (rc) begin
                    m_mode = 2; nphase = 0;
                end else if (rh) begin
                    m_score = (m_score + 1) % 100;
                end
            end
            default: if (m_phase == int'(HOLD_SEC) * SEC - 1) m_mode = 0;
        endcase
        m_phase = nphase;
    endtask

    // Game model: one expected snapshot per clock, replaced on async reset.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = 0; m_phase = 0; m_secs = 0; m_score = 0;
            m_ps = 0; m_ph = 0; m_pc = 0;
            exp_q.delete();
        end else begin
            model_step();
        end
        exp_q.push_back(m_snap());
    end

    // Counter model.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            c_cnt = 0;
            cexp_q.delete();
        end else if (clr_t) begin
            c_cnt = 0;
        end else if (inc_t) begin
            c_cnt = (c_cnt + 1) % 10000;
        end
        cexp_q.push_back(to_bcd(c_cnt));
    end

    // Monitor: compare every presented cycle on the falling edge.
    initial forever begin
        snap_t e, a;
        logic [15:0] ce;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, playing, hold, frame_tick, timer_bcd, score_bcd};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL outputs t=%0t got st=%0d ply=%b hld=%b ft=%b tmr=%h scr=%h want st=%0d ply=%b hld=%b ft=%b tmr=%h scr=%h",
                         $time, a.st, a.ply, a.hld, a.ft, a.tmr, a.scr, e.st, e.ply, e.hld, e.ft, e.tmr, e.scr);
            end
        end
        if (cexp_q.size() > 0) begin
            ce = cexp_q.pop_front();
            total++;
            if (cnt_out !== ce) begin
                bad++;
                $display("FAIL bcd4 t=%0t got=%h want=%h", $time, cnt_out, ce);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_hit(input int n);
        repeat (n) begin
            hit = 1'b1; cyc(1);
            hit = 1'b0; cyc(1);
        end
    endtask

    task automatic main_seq();
        cyc(2);
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_timer", int'(timer_bcd), 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        start = 1'b1; cyc(1); start = 1'b0;
        #1 chk("play_entry", int'(state), 1);
        cyc(130);
        #1 chk("timer_2s", int'(timer_bcd), 'h0002);
        pulse_hit(12);
        #1 chk("score_12", int'(score_bcd), 'h12);
        pulse_hit(87);
        #1 chk("score_99", int'(score_bcd), 'h99);
        pulse_hit(1);
        #1 chk("score_wrap", int'(score_bcd), 'h00);
        pulse_hit(3);
        hit = 1'b1; crash = 1'b1; cyc(1); hit = 1'b0; crash = 1'b0;
        #1 chk("crash_state", int'(state), 2);
        chk("crash_score", int'(score_bcd), 'h03);
        cyc(10);
        pulse_hit(1);
        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        crash = 1'b1; cyc(1); crash = 1'b0; cyc(1);
        cyc(102);
        #1 chk("over_hold", int'(state), 2);
        cyc(2);
        #1 chk("over_exit", int'(state), 0);
        chk("frozen_score", int'(score_bcd), 'h03);
        cyc(1);
        start = 1'b1; cyc(1); start = 1'b0;
        #1 chk("restart_timer", int'(timer_bcd), 0);
        chk("restart_score", int'(score_bcd), 0);
        // start held through reset release
        cyc(1);
        start = 1'b1; rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        #1 chk("held_start", int'(state), 1);
        cyc(100);
        start = 1'b0;
        pulse_hit(5);
        crash = 1'b1; cyc(1); crash = 1'b0;
        cyc(40);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_hold", int'(hold), 0);
        chk("async_timer", int'(timer_bcd), 0);
        chk("async_score", int'(score_bcd), 0);
        cyc(3);
        rst_n = 1'b1;
        cyc(70);
        #1 chk("idle_after_rst", int'(state), 0);
        repeat (12000) begin
            cyc(1);
            start = ($urandom % 16) == 0;
            hit   = ($urandom % 4) == 0;
            crash = ($urandom % 300) == 0;
        end
        start = 1'b0; hit = 1'b0; crash = 1'b0;
    endtask

    task automatic cnt_seq();
        cyc(4);
        repeat (300) begin
            inc_t = 1'($urandom % 2);
            clr_t = ($urandom % 40) == 0;
            cyc(1);
        end
        clr_t = 1'b0;
        inc_t = 1'b1;
        cyc(12000);
        inc_t = 1'b0;
    endtask

    initial begin
        fork
            main_seq();
            cnt_seq();
        join
        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
